// File: rtl/smart_house_pkg.sv
// Shared types, ASCII constants and command strings for the smart-house
// command transmitter.
package smart_house_pkg;

   localparam int unsigned CHAR_W  = 8;
   localparam int unsigned IDX_W   = 4;
   localparam int unsigned MAX_LEN = 11;
   localparam int unsigned STR_W   = CHAR_W * MAX_LEN;

   typedef enum logic [1:0] {
      CMD_OPEN_WINDOW  = 2'd0,
      CMD_CLOSE_WINDOW = 2'd1,
      CMD_MUSIC_ON     = 2'd2,
      CMD_LIGHT_ON     = 2'd3
   } cmd_code_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_GAP
   } tx_state_e;

   localparam logic [CHAR_W-1:0] CH_NUL = 8'h00;
   localparam logic [CHAR_W-1:0] CH_C   = 8'h63;
   localparam logic [CHAR_W-1:0] CH_D   = 8'h64;
   localparam logic [CHAR_W-1:0] CH_E   = 8'h65;
   localparam logic [CHAR_W-1:0] CH_G   = 8'h67;
   localparam logic [CHAR_W-1:0] CH_H   = 8'h68;
   localparam logic [CHAR_W-1:0] CH_I   = 8'h69;
   localparam logic [CHAR_W-1:0] CH_L   = 8'h6C;
   localparam logic [CHAR_W-1:0] CH_M   = 8'h6D;
   localparam logic [CHAR_W-1:0] CH_N   = 8'h6E;
   localparam logic [CHAR_W-1:0] CH_O   = 8'h6F;
   localparam logic [CHAR_W-1:0] CH_P   = 8'h70;
   localparam logic [CHAR_W-1:0] CH_S   = 8'h73;
   localparam logic [CHAR_W-1:0] CH_T   = 8'h74;
   localparam logic [CHAR_W-1:0] CH_U   = 8'h75;
   localparam logic [CHAR_W-1:0] CH_W   = 8'h77;

   localparam logic [IDX_W-1:0] LEN_OPEN_WINDOW  = 4'd10;
   localparam logic [IDX_W-1:0] LEN_CLOSE_WINDOW = 4'd11;
   localparam logic [IDX_W-1:0] LEN_MUSIC_ON     = 4'd7;
   localparam logic [IDX_W-1:0] LEN_LIGHT_ON     = 4'd7;

   // Strings are left-aligned: character 0 sits in the most significant byte.
   localparam logic [STR_W-1:0] STR_OPEN_WINDOW =
      {CH_O, CH_P, CH_E, CH_N, CH_W, CH_I, CH_N, CH_D, CH_O, CH_W, CH_NUL};
   localparam logic [STR_W-1:0] STR_CLOSE_WINDOW =
      {CH_C, CH_L, CH_O, CH_S, CH_E, CH_W, CH_I, CH_N, CH_D, CH_O, CH_W};
   localparam logic [STR_W-1:0] STR_MUSIC_ON =
      {CH_M, CH_U, CH_S, CH_I, CH_C, CH_O, CH_N, CH_NUL, CH_NUL, CH_NUL, CH_NUL};
   localparam logic [STR_W-1:0] STR_LIGHT_ON =
      {CH_L, CH_I, CH_G, CH_H, CH_T, CH_O, CH_N, CH_NUL, CH_NUL, CH_NUL, CH_NUL};

   function automatic logic [CHAR_W-1:0] str_char(input logic [STR_W-1:0] str,
                                                  input logic [IDX_W-1:0] idx);
      logic [CHAR_W-1:0] ch;
      ch = CH_NUL;
      for (int unsigned i = 0; i < MAX_LEN; i++) begin
         if (idx == IDX_W'(i)) ch = CHAR_W'(str >> ((MAX_LEN - 1 - i) * CHAR_W));
      end
      return ch;
   endfunction

endpackage

// File: rtl/smart_house_cmd_rom.sv
// Command string ROM: maps (command, character index) to the ASCII character
// and reports the command's string length.
module smart_house_cmd_rom
   import smart_house_pkg::*;
(
   input  cmd_code_e         cmd_i,
   input  logic [IDX_W-1:0]  idx_i,
   output logic [CHAR_W-1:0] char_o,
   output logic [IDX_W-1:0]  len_o
);

   logic [STR_W-1:0] str;

   always_comb begin
      str   = STR_OPEN_WINDOW;
      len_o = LEN_OPEN_WINDOW;
      case (cmd_i)
         CMD_OPEN_WINDOW:  begin str = STR_OPEN_WINDOW;  len_o = LEN_OPEN_WINDOW;  end
         CMD_CLOSE_WINDOW: begin str = STR_CLOSE_WINDOW; len_o = LEN_CLOSE_WINDOW; end
         CMD_MUSIC_ON:     begin str = STR_MUSIC_ON;     len_o = LEN_MUSIC_ON;     end
         CMD_LIGHT_ON:     begin str = STR_LIGHT_ON;     len_o = LEN_LIGHT_ON;     end
      endcase
      char_o = (idx_i < len_o) ? str_char(str, idx_i) : CH_NUL;
   end

endmodule

// File: rtl/smart_house_cmd_tx.sv
// Queues smart-house commands and streams each one to the controller as an
// ASCII string with a valid/ready handshake, followed by an idle gap.
module smart_house_cmd_tx
   import smart_house_pkg::*;
#(
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   input  logic [1:0]        cmd_code,
   output logic              cmd_ready,
   output logic [CHAR_W-1:0] char_out,
   output logic              char_valid,
   input  logic              char_ready,
   input  logic              abort,
   output logic              busy,
   output logic              cmd_done
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   tx_state_e         state_q, state_d, after_cmd;
   cmd_code_e         fifo_q [FIFO_DEPTH];
   cmd_code_e         cmd_q, cmd_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  idx_q, idx_d, len_q, len_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [CHAR_W-1:0] char_q, char_d, rom_char;
   logic [IDX_W-1:0]  rom_len;
   logic              cmd_ready_q, cmd_ready_d;
   logic              char_valid_q, char_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              push, pop, fifo_empty, xfer, last_char;

   // ROM is addressed with next-state values so char_out can be registered.
   smart_house_cmd_rom u_rom (
      .cmd_i  (cmd_d),
      .idx_i  (idx_d),
      .char_o (rom_char),
      .len_o  (rom_len)
   );

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      idx_d      = idx_q;
      gap_d      = gap_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      done_d     = 1'b0;
      pop        = 1'b0;
      push       = cmd_valid && cmd_ready_q;
      fifo_empty = (count_q == '0);
      xfer       = char_valid_q && char_ready;
      last_char  = (idx_q == len_q - IDX_W'(1));
      after_cmd  = (GAP_CYCLES != 0) ? ST_GAP : (fifo_empty ? ST_IDLE : ST_LOAD);

      case (state_q)
         ST_IDLE: if (!fifo_empty) state_d = ST_LOAD;
         ST_LOAD: begin
            pop      = 1'b1;
            cmd_d    = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            idx_d    = '0;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            // A last-character transfer wins over a coincident abort.
            if (xfer && last_char) begin
               done_d  = 1'b1;
               gap_d   = '0;
               state_d = after_cmd;
            end else if (abort) begin
               gap_d   = '0;
               state_d = after_cmd;
            end else if (xfer) begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         ST_GAP: begin
            if (gap_q == GAP_LAST) state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            else                   gap_d   = gap_q + GAP_W'(1);
         end
         default: state_d = ST_IDLE;
      endcase

      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
      cmd_ready_d  = (count_d < CNT_W'(FIFO_DEPTH));
      busy_d       = (count_d != '0) || (state_d != ST_IDLE);
      char_valid_d = (state_d == ST_SEND);
   end

   always_comb begin
      len_d  = (state_q == ST_LOAD) ? rom_len : len_q;
      char_d = char_valid_d ? rom_char : CH_NUL;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cmd_q        <= CMD_OPEN_WINDOW;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         idx_q        <= '0;
         len_q        <= '0;
         gap_q        <= '0;
         char_q       <= CH_NUL;
         cmd_ready_q  <= 1'b1;
         char_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cmd_q        <= cmd_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         idx_q        <= idx_d;
         len_q        <= len_d;
         gap_q        <= gap_d;
         char_q       <= char_d;
         cmd_ready_q  <= cmd_ready_d;
         char_valid_q <= char_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo_q[wr_ptr_q] <= cmd_code_e'(cmd_code);
   end

   assign cmd_ready  = cmd_ready_q;
   assign char_out   = char_q;
   assign char_valid = char_valid_q;
   assign busy       = busy_q;
   assign cmd_done   = done_q;

endmodule

// File: tb/tb_smart_house_cmd_tx.sv
// Directed bench for smart_house_cmd_tx: a per-cycle vector table plus
// hand-written sequences for back-pressure, abort and mid-command reset.
module tb_smart_house_cmd_tx;

   logic       clock = 1'b0;
   logic       reset, cmd_valid, char_ready, abort;
   logic [1:0] cmd_code;
   logic       cmd_ready, char_valid, busy, cmd_done;
   logic [7:0] char_out;

   always #5 clock = ~clock;

   smart_house_cmd_tx #(.GAP_CYCLES(2), .FIFO_DEPTH(2)) dut (
      .clock      (clock),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_ready  (cmd_ready),
      .char_out   (char_out),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .abort      (abort),
      .busy       (busy),
      .cmd_done   (cmd_done)
   );

   typedef struct {
      logic       cmd_valid;
      logic [1:0] cmd_code;
      logic       char_ready;
      logic       abort;
      logic       e_valid;
      logic [7:0] e_char;
      logic       e_done;
      logic       e_busy;
      logic       e_ready;
   } vec_t;

   vec_t       vecs[$];
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] got[$];
   int         runs[$];
   int         dones;
   int         drain_cycles;

   function automatic string cmd_str(input int c);
      case (c)
         0:       return "openwindow";
         1:       return "closewindow";
         2:       return "musicon";
         default: return "lighton";
      endcase
   endfunction

   function automatic void add(input int v, input int c, input int cr, input int ab,
                               input int ev, input int ech, input int ed, input int eb,
                               input int er);
      vec_t r;
      r.cmd_valid  = 1'(v);
      r.cmd_code   = 2'(c);
      r.char_ready = 1'(cr);
      r.abort      = 1'(ab);
      r.e_valid    = 1'(ev);
      r.e_char     = 8'(ech);
      r.e_done     = 1'(ed);
      r.e_busy     = 1'(eb);
      r.e_ready    = 1'(er);
      vecs.push_back(r);
   endfunction

   // One SEND row per character, controller always ready.
   function automatic void add_chars(input string s);
      for (int i = 0; i < s.len(); i++) add(0, 0, 1, 0, 1, int'(s[i]), 0, 1, 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Hold cmd_valid until the command is taken.
   task automatic push(input int c);
      int t;
      t = 0;
      cmd_valid = 1'b1;
      cmd_code  = 2'(c);
      while (cmd_ready !== 1'b1 && t < 50) begin
         step();
         t++;
      end
      chk("push_ready", 32'(cmd_ready), 1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_char(input string name, input logic [7:0] ch);
      int t;
      t = 0;
      while (!(char_valid === 1'b1 && char_out === ch) && t < 50) begin
         step();
         t++;
      end
      chk(name, 32'(char_out), 32'(ch));
   endtask

   // Run until idle, collecting characters, done pulses and idle-run lengths.
   task automatic drain(input string name);
      int run;
      got.delete();
      runs.delete();
      dones        = 0;
      run          = 0;
      drain_cycles = 0;
      while (busy === 1'b1 && drain_cycles < 400) begin
         if (cmd_done === 1'b1) dones++;
         if (char_valid === 1'b1) begin
            if (run > 0) runs.push_back(run);
            run = 0;
            got.push_back(char_out);
         end else begin
            run++;
         end
         step();
         drain_cycles++;
      end
      chk({name, "_idle"}, 32'(busy), 0);
   endtask

   task automatic chk_got(input string name, input string exp);
      chk({name, "_len"}, 32'(got.size()), 32'(exp.len()));
      foreach (got[i]) begin
         if (i < exp.len()) chk($sformatf("%s_c%0d", name, i), 32'(got[i]), 32'(exp[i]));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      cmd_valid  = 1'b1;
      cmd_code   = 2'd0;
      char_ready = 1'b1;
      abort      = 1'b0;

      // OPEN_WINDOW end to end; abort pulses in GAP and LOAD must be ignored.
      add(1, 0, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 1);
      add_chars("openwindow");
      add(0, 0, 1, 1, 0, 0, 1, 1, 1);
      add(0, 0, 1, 1, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1);
      // MUSIC_ON with the controller stalling on 'u'.
      add(1, 2, 1, 0, 0, 0, 0, 0, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 1, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 1, 'h6D, 0, 1, 1);
      add(0, 0, 0, 0, 1, 'h75, 0, 1, 1);
      add(0, 0, 0, 0, 1, 'h75, 0, 1, 1);
      add(0, 0, 0, 0, 1, 'h75, 0, 1, 1);
      add(0, 0, 1, 0, 1, 'h75, 0, 1, 1);
      add_chars("sicon");
      add(0, 0, 1, 0, 0, 0, 1, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 1, 1);
      add(0, 0, 1, 0, 0, 0, 0, 0, 1);

      // Reset with a command offered: it must be discarded.
      step();
      step();
      reset     = 1'b0;
      cmd_valid = 1'b0;
      chk("rst_cmd_ready", 32'(cmd_ready), 1);
      chk("rst_char_valid", 32'(char_valid), 0);
      chk("rst_char_out", 32'(char_out), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cmd_done", 32'(cmd_done), 0);
      step();
      chk("rst_discard_busy", 32'(busy), 0);

      foreach (vecs[k]) begin
         cmd_valid  = vecs[k].cmd_valid;
         cmd_code   = vecs[k].cmd_code;
         char_ready = vecs[k].char_ready;
         abort      = vecs[k].abort;
         chk($sformatf("v%0d_char_valid", k), 32'(char_valid), 32'(vecs[k].e_valid));
         chk($sformatf("v%0d_char_out", k), 32'(char_out), 32'(vecs[k].e_char));
         chk($sformatf("v%0d_cmd_done", k), 32'(cmd_done), 32'(vecs[k].e_done));
         chk($sformatf("v%0d_busy", k), 32'(busy), 32'(vecs[k].e_busy));
         chk($sformatf("v%0d_cmd_ready", k), 32'(cmd_ready), 32'(vecs[k].e_ready));
         step();
      end
      cmd_valid  = 1'b0;
      abort      = 1'b0;
      char_ready = 1'b1;

      // Back-to-back pushes with the controller stalled.
      char_ready = 1'b0;
      cmd_valid  = 1'b1;
      cmd_code   = 2'd3;
      chk("A_ready0", 32'(cmd_ready), 1);
      step();
      cmd_code = 2'd1;
      chk("A_ready1", 32'(cmd_ready), 1);
      step();
      cmd_code = 2'd2;
      chk("A_full", 32'(cmd_ready), 0);
      step();
      chk("A_ready_after_pop", 32'(cmd_ready), 1);
      chk("A_first_char", 32'(char_out), 'h6C);
      step();
      cmd_code = 2'd0;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("A_refused%0d", i), 32'(cmd_ready), 0);
         chk($sformatf("A_hold%0d", i), 32'(char_out), 'h6C);
         step();
      end
      cmd_valid  = 1'b0;
      char_ready = 1'b1;
      drain("A");
      chk_got("A", {cmd_str(3), cmd_str(1), cmd_str(2)});
      chk("A_dones", 32'(dones), 3);
      chk("A_runs", 32'(runs.size()), 2);
      foreach (runs[i]) chk($sformatf("A_run%0d", i), 32'(runs[i]), 3);

      // Abort on the 4th character of CLOSE_WINDOW with LIGHT_ON queued.
      push(1);
      push(3);
      wait_char("B_wait_s", 8'h73);
      abort      = 1'b1;
      char_ready = 1'b0;
      step();
      abort      = 1'b0;
      char_ready = 1'b1;
      chk("B_abort_valid", 32'(char_valid), 0);
      chk("B_abort_char", 32'(char_out), 0);
      chk("B_abort_done", 32'(cmd_done), 0);
      drain("B");
      chk_got("B", cmd_str(3));
      chk("B_dones", 32'(dones), 1);
      chk("B_runs", 32'(runs.size()), 1);
      foreach (runs[i]) chk($sformatf("B_run%0d", i), 32'(runs[i]), 3);

      // Reset mid-SEND of OPEN_WINDOW with CLOSE_WINDOW queued.
      push(0);
      push(1);
      wait_char("C_wait_e", 8'h65);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("C_valid", 32'(char_valid), 0);
      chk("C_char", 32'(char_out), 0);
      chk("C_busy", 32'(busy), 0);
      chk("C_ready", 32'(cmd_ready), 1);
      step();
      chk("C_busy_later", 32'(busy), 0);
      push(2);
      drain("C");
      chk_got("C", cmd_str(2));
      chk("C_dones", 32'(dones), 1);

      // Abort coinciding with the last-character transfer of LIGHT_ON.
      push(3);
      wait_char("D_wait_n", 8'h6E);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("D_done", 32'(cmd_done), 1);
      chk("D_valid", 32'(char_valid), 0);
      drain("D");
      chk("D_dones", 32'(dones), 1);
      chk("D_extra_chars", 32'(got.size()), 0);
      chk("D_gap_cycles", 32'(drain_cycles), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
